present_round_ctrl: RTL and testbench
=====================================

Name: present_round_ctrl

Overview:
Parametrised round controller for the PRESENT cipher core. It is the next generation of the v0 round counter and supports any N_ROUNDS/ROUNDS_PER_CYCLE unrolling. It adds a start/ready handshake, encrypt/decrypt direction, synchronous abort and a last-cycle flag. It drives the round index, load strobe and end-of-computation pulse for the state/key datapath.

Parameters:
N_ROUNDS, 31, number of cipher rounds; must be divisible by ROUNDS_PER_CYCLE (elaboration-time $fatal otherwise).
ROUNDS_PER_CYCLE, 1, rounds computed per clock (unroll factor).
NCYC, N_ROUNDS/ROUNDS_PER_CYCLE, derived localparam: compute cycles per block.
ROUND_W, $clog2(NCYC+1), derived localparam: width of round_o (5 at defaults).

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
start_i  in  1  request new block; accepted only when ready_o=1
mode_i  in  1  0=encrypt, 1=decrypt; sampled on acceptance
abort_i  in  1  synchronous abort, highest priority
ready_o  in/out: out  1  controller can accept start (IDLE or DONE), combinational
load_o  out  1  combinational: start_i & ready_o & ~abort_i; datapath loads text/key this cycle
busy_o  out  1  registered; 1 in RUN (and KEYPRE)
round_o  out  ROUND_W  registered cycle index; 0 when not computing
last_o  out  1  registered; 1 in final RUN cycle
dec_o  out  1  registered latched mode
key_fwd_o  out  1  registered; key-schedule forward-run strobe (see Optional Feature)
eoc_o  out  1  registered; one-cycle end-of-computation pulse

Behaviour:
- Reset (nrst=0, async): state IDLE; round_o=0, busy_o=0, last_o=0, dec_o=0, key_fwd_o=0, eoc_o=0; ready_o=1 after reset.
- States: IDLE, RUN, DONE (plus KEYPRE with the optional feature).
- IDLE: ready_o=1, round_o=0. Accepted start at cycle T (load_o=1) -> RUN at T+1; dec_o<=mode_i.
- RUN, encrypt: round_o = 1,2,...,NCYC on consecutive cycles T+1..T+NCYC.
- RUN, decrypt: round_o = NCYC,...,1.
- RUN: last_o=1 only in the final RUN cycle. The following cycle enters DONE.
- DONE: lasts exactly one cycle; eoc_o=1, round_o=0, busy_o=0, ready_o=1. Next state IDLE, or RUN if a start is accepted in DONE (back-to-back, zero gap).
- Latency: start accepted at T -> eoc_o at T+NCYC+1 (T+32 at defaults).
- start_i, mode_i while ready_o=0: ignored, no effect on count or dec_o.
- abort_i=1 in any state: next cycle IDLE, round_o=0, busy_o=0, last_o=0, key_fwd_o=0, eoc_o=0. No eoc is ever issued for an aborted block.
- abort_i with start_i in the same cycle: abort wins, load_o=0, start dropped.
- Reset mid-operation: immediate return to reset values; no eoc_o.
- Counter never wraps: round_o stays within 0..NCYC.
- NCYC=1 (full unroll): single RUN cycle with round_o=1 and last_o=1; eoc_o at T+2.

Optional Feature:
Macro PRESENT_CTRL_KEYPRE_EN.
- Defined:
  - An accepted decrypt start goes IDLE/DONE -> KEYPRE for NCYC cycles, with key_fwd_o=1 and round_o=1..NCYC. The key register runs the schedule forward to the last round key.
  - KEYPRE then goes to RUN (round_o NCYC..1, key_fwd_o=0).
  - Decrypt latency becomes eoc_o at T+2*NCYC+1.
  - busy_o=1 in KEYPRE; abort applies in KEYPRE.
  - Encrypt is unaffected.
- Undefined: no KEYPRE state; key_fwd_o tied 0; decrypt enters RUN directly. The last round key is supplied externally.

Test Plan:
1. Assert nrst=0 mid-RUN at round_o=7 -> all outputs to reset values immediately; ready_o=1; no eoc_o after release.
2. Encrypt at defaults, start at T -> load_o=1 at T; round_o 1..31 at T+1..T+31; last_o=1 at T+31; eoc_o=1 only at T+32 with round_o=0.
3. Decrypt, macro undefined -> dec_o=1, round_o 31..1, eoc_o at T+32; mode_i toggled during RUN has no effect.
4. start_i held high through DONE -> accepted in DONE cycle; round_o=1 the next cycle, no IDLE gap; start pulses during RUN are ignored.
5. abort_i at round_o=10 -> IDLE next cycle, no eoc_o; abort_i+start_i same cycle in IDLE -> load_o=0, stays IDLE.
6. Macro defined, decrypt -> key_fwd_o=1 with round_o 1..31, then RUN 31..1, eoc_o at T+63; ROUNDS_PER_CYCLE=31 build: eoc_o at T+2.

Source files
------------

// File: rtl/present_round_ctrl.sv
// present_round_ctrl: round controller for the PRESENT cipher core.
// Sequences NCYC = N_ROUNDS/ROUNDS_PER_CYCLE compute cycles per block.
// It drives the round index, the load strobe and a one-cycle end-of-computation
// pulse for the state/key datapath.
//
// Build option: define PRESENT_CTRL_KEYPRE_EN to add a KEYPRE phase ahead of
// decryption. In that phase the key register runs the schedule forward to the
// last round key. With the macro undefined there is no KEYPRE state,
// key_fwd_o is tied low, and the last round key must be supplied externally.
//
// Handshake: the controller is ready (ready_o=1) only in IDLE or DONE. A
// block is accepted in any cycle where start_i & ready_o & ~abort_i, which is
// exactly load_o. mode_i is sampled in that same cycle. While ready_o=0,
// start_i and mode_i are ignored. abort_i has priority over everything else.
module present_round_ctrl #(
    parameter int N_ROUNDS         = 31,
    parameter int ROUNDS_PER_CYCLE = 1,
    localparam int NCYC    = N_ROUNDS / ROUNDS_PER_CYCLE,
    localparam int ROUND_W = $clog2(NCYC + 1)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic               abort_i,
    output logic               ready_o,
    output logic               load_o,
    output logic               busy_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               last_o,
    output logic               dec_o,
    output logic               key_fwd_o,
    output logic               eoc_o
);

    // Reject unroll factors that do not divide the round count.
    if ((N_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_unroll
        $fatal(1, "present_round_ctrl: N_ROUNDS must be divisible by ROUNDS_PER_CYCLE");
    end

    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NCYC);
    localparam logic [ROUND_W-1:0] ONE_RND  = ROUND_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DONE   = 2'd2,
        S_KEYPRE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               busy_q, busy_d;
    logic               last_q, last_d;
    logic               dec_q, dec_d;
    logic               eoc_q, eoc_d;
    logic [ROUND_W-1:0] round_inc, round_dec;

    assign round_inc = round_q + ONE_RND;
    assign round_dec = round_q - ONE_RND;

    // Handshake strobes are combinational so a start can be taken in DONE.
    assign ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
    assign load_o  = start_i & ready_o & ~abort_i;

`ifdef PRESENT_CTRL_KEYPRE_EN
    logic key_fwd_q, key_fwd_d;
`endif

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        busy_d  = busy_q;
        last_d  = 1'b0;
        dec_d   = dec_q;
        eoc_d   = 1'b0;
`ifdef PRESENT_CTRL_KEYPRE_EN
        key_fwd_d = 1'b0;
`endif
        if (abort_i) begin
            state_d = S_IDLE;
            round_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (load_o) begin
                        dec_d  = mode_i;
                        busy_d = 1'b1;
`ifdef PRESENT_CTRL_KEYPRE_EN
                        if (mode_i) begin
                            // Forward key run first, counting up like encrypt.
                            state_d   = S_KEYPRE;
                            round_d   = ONE_RND;
                            key_fwd_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            round_d = ONE_RND;
                            last_d  = (ONE_RND == LAST_RND);
                        end
`else
                        state_d = S_RUN;
                        round_d = mode_i ? LAST_RND : ONE_RND;
                        last_d  = (NCYC == 1);
`endif
                    end else begin
                        state_d = S_IDLE;
                        round_d = '0;
                        busy_d  = 1'b0;
                    end
                end
                S_RUN: begin
                    if (last_q) begin
                        state_d = S_DONE;
                        round_d = '0;
                        busy_d  = 1'b0;
                        eoc_d   = 1'b1;
                    end else if (dec_q) begin
                        round_d = round_dec;
                        last_d  = (round_dec == ONE_RND);
                    end else begin
                        round_d = round_inc;
                        last_d  = (round_inc == LAST_RND);
                    end
                end
`ifdef PRESENT_CTRL_KEYPRE_EN
                S_KEYPRE: begin
                    if (round_q == LAST_RND) begin
                        // Key now holds the last round key; decrypt counts down.
                        state_d = S_RUN;
                        round_d = LAST_RND;
                        last_d  = (NCYC == 1);
                    end else begin
                        round_d   = round_inc;
                        key_fwd_d = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    round_d = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously by nrst.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            dec_q   <= 1'b0;
            eoc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            dec_q   <= dec_d;
            eoc_q   <= eoc_d;
        end
    end

`ifdef PRESENT_CTRL_KEYPRE_EN
    // Key-schedule forward-run strobe register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            key_fwd_q <= 1'b0;
        end else begin
            key_fwd_q <= key_fwd_d;
        end
    end
    assign key_fwd_o = key_fwd_q;
`else
    assign key_fwd_o = 1'b0;
`endif

    assign round_o = round_q;
    assign busy_o  = busy_q;
    assign last_o  = last_q;
    assign dec_o   = dec_q;
    assign eoc_o   = eoc_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Directed bench for present_round_ctrl at defaults (NCYC=31) plus a fully
// unrolled instance (ROUNDS_PER_CYCLE=31, NCYC=1).
module tb_present_round_ctrl;

    localparam int NCYC = 31;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // ---------------- DUT (defaults) ----------------
    logic       start_i, mode_i, abort_i;
    logic       ready_o, load_o, busy_o, last_o, dec_o, key_fwd_o, eoc_o;
    logic [4:0] round_o;

    present_round_ctrl dut (
        .clk      (clk),
        .nrst     (nrst),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .abort_i  (abort_i),
        .ready_o  (ready_o),
        .load_o   (load_o),
        .busy_o   (busy_o),
        .round_o  (round_o),
        .last_o   (last_o),
        .dec_o    (dec_o),
        .key_fwd_o(key_fwd_o),
        .eoc_o    (eoc_o)
    );

    // ---------------- DUT (full unroll) ----------------
    logic       u_start, u_mode, u_abort;
    logic       u_ready, u_load, u_busy, u_last, u_dec, u_key_fwd, u_eoc;
    logic [0:0] u_round;

    present_round_ctrl #(.N_ROUNDS(31), .ROUNDS_PER_CYCLE(31)) dut_unr (
        .clk      (clk),
        .nrst     (nrst),
        .start_i  (u_start),
        .mode_i   (u_mode),
        .abort_i  (u_abort),
        .ready_o  (u_ready),
        .load_o   (u_load),
        .busy_o   (u_busy),
        .round_o  (u_round),
        .last_o   (u_last),
        .dec_o    (u_dec),
        .key_fwd_o(u_key_fwd),
        .eoc_o    (u_eoc)
    );

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: inputs are changed at negedge, outputs read at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".round"}, 32'(round_o), 0);
        check_val({tag, ".busy"},  32'(busy_o),  0);
        check_val({tag, ".last"},  32'(last_o),  0);
        check_val({tag, ".eoc"},   32'(eoc_o),   0);
        check_val({tag, ".kfwd"},  32'(key_fwd_o), 0);
        check_val({tag, ".ready"}, 32'(ready_o), 1);
    endtask

    // Pops the expected round sequence from exp_q, one per RUN cycle.
    task automatic run_seq(input string tag, input logic exp_dec, input logic kfwd);
        int k = 0;
        while (exp_q.size() > 0) begin
            logic [4:0] r;
            r = exp_q.pop_front();
            k++;
            check_val({tag, ".round"}, 32'(round_o), 32'(r));
            check_val({tag, ".busy"},  32'(busy_o), 1);
            check_val({tag, ".ready"}, 32'(ready_o), 0);
            check_val({tag, ".eoc"},   32'(eoc_o), 0);
            check_val({tag, ".dec"},   32'(dec_o), 32'(exp_dec));
            check_val({tag, ".kfwd"},  32'(key_fwd_o), 32'(kfwd));
            check_val({tag, ".last"},  32'(last_o), (!kfwd && exp_q.size() == 0) ? 1 : 0);
            // Inputs toggled mid-run must have no effect.
            mode_i = ~mode_i;
            step();
        end
    endtask

    task automatic push_up();
        for (int i = 1; i <= NCYC; i++) exp_q.push_back(5'(i));
    endtask

    task automatic push_down();
        for (int i = NCYC; i >= 1; i--) exp_q.push_back(5'(i));
    endtask

    task automatic check_done(input string tag);
        check_val({tag, ".eoc"},   32'(eoc_o), 1);
        check_val({tag, ".round"}, 32'(round_o), 0);
        check_val({tag, ".busy"},  32'(busy_o), 0);
        check_val({tag, ".ready"}, 32'(ready_o), 1);
    endtask

    task automatic accept(input logic m, input string tag);
        start_i = 1'b1;
        mode_i  = m;
        #1;
        check_val({tag, ".load"}, 32'(load_o), 1);
        step();
        start_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nrst = 1'b0; start_i = 0; mode_i = 0; abort_i = 0;
        u_start = 0; u_mode = 0; u_abort = 0;
        repeat (2) @(negedge clk);
        #1;
        check_idle("rst");
        check_val("rst.dec", 32'(dec_o), 0);
        nrst = 1'b1;
        step();
        check_idle("idle");

        // Encrypt: round 1..31, last at 31, eoc at T+32.
        accept(1'b0, "enc");
        push_up();
        run_seq("enc", 1'b0, 1'b0);
        check_done("enc.done");
        step();
        check_idle("enc.idle");

        // Decrypt.
        accept(1'b1, "dec");
`ifdef PRESENT_CTRL_KEYPRE_EN
        push_up();
        run_seq("dec.kpre", 1'b1, 1'b1);
`endif
        push_down();
        run_seq("dec", 1'b1, 1'b0);
        check_done("dec.done");
        check_val("dec.hold", 32'(dec_o), 1);
        step();

        // Back-to-back: start held high through the run and DONE.
        mode_i = 1'b0;
        accept(1'b0, "b2b");
        start_i = 1'b1;
        push_up();
        begin
            int k = 0;
            while (exp_q.size() > 0) begin
                logic [4:0] r;
                r = exp_q.pop_front();
                check_val("b2b.round", 32'(round_o), 32'(r));
                check_val("b2b.load_blocked", 32'(load_o), 0);
                step();
            end
        end
        check_done("b2b.done");
        check_val("b2b.load", 32'(load_o), 1);
        step();
        start_i = 1'b0;
        check_val("b2b.round1", 32'(round_o), 1);
        check_val("b2b.busy", 32'(busy_o), 1);

        // Abort at round 10 of the second block.
        for (int i = 2; i <= 10; i++) step();
        check_val("abort.round10", 32'(round_o), 10);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 35; i++) begin
            check_val("abort.no_eoc", 32'(eoc_o), 0);
            step();
        end

        // Abort and start together in IDLE: start dropped.
        abort_i = 1'b1;
        start_i = 1'b1;
        #1;
        check_val("abst.load", 32'(load_o), 0);
        step();
        abort_i = 1'b0;
        start_i = 1'b0;
        check_idle("abst");

        // Reset mid-run at round 7.
        accept(1'b0, "rmid");
        for (int i = 2; i <= 7; i++) step();
        check_val("rmid.round7", 32'(round_o), 7);
        nrst = 1'b0;
        #1;
        check_idle("rmid");
        check_val("rmid.dec", 32'(dec_o), 0);
        step();
        nrst = 1'b1;
        for (int i = 0; i < 35; i++) begin
            check_val("rmid.no_eoc", 32'(eoc_o), 0);
            step();
        end

        // Fully unrolled instance: single RUN cycle, eoc at T+2.
        u_start = 1'b1;
        #1;
        check_val("unr.load", 32'(u_load), 1);
        step();
        u_start = 1'b0;
        check_val("unr.round", 32'(u_round), 1);
        check_val("unr.last", 32'(u_last), 1);
        check_val("unr.busy", 32'(u_busy), 1);
        check_val("unr.eoc0", 32'(u_eoc), 0);
        step();
        check_val("unr.eoc", 32'(u_eoc), 1);
        check_val("unr.round0", 32'(u_round), 0);
        step();
        check_val("unr.idle_eoc", 32'(u_eoc), 0);
        check_val("unr.ready", 32'(u_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
